// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Package  : decode_pkg
// Purpose  : Shared encodings and the control bundle type for the ID-stage
//            decoder of the ARM-subset pipeline.
// Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

    // Instruction classes, taken from instr[27:25]
    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BR     = 3'b101;

    // Shifter addressing modes
    localparam logic [1:0] AM_ROT_IMM   = 2'b00;
    localparam logic [1:0] AM_SHIFT_IMM = 2'b01;
    localparam logic [1:0] AM_LS_IMM    = 2'b10;
    localparam logic [1:0] AM_LS_REG    = 2'b11;

    // ALU opcodes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSB = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SBC = 4'b0110;
    localparam logic [3:0] ALU_RSC = 4'b0111;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_BIC = 4'b1110;
    localparam logic [3:0] ALU_MVN = 4'b1111;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Control bundle passed through the stall mux
    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] am;
        logic       s_enable;
        logic       load_instr;
        logic       rf_enable;
        logic       size_enable;
        logic       rw_enable;
        logic       enable_signal;
        logic       bl_instr;
        logic       b_instr;
    } ctrl_t;

    // 6-character space-padded mnemonic for a data-processing opcode
    function automatic logic [47:0] dp_mnemonic(input logic [3:0] op);
        logic [47:0] kw;
        case (op)
            ALU_AND: kw = "AND   ";
            ALU_EOR: kw = "EOR   ";
            ALU_SUB: kw = "SUB   ";
            ALU_RSB: kw = "RSB   ";
            ALU_ADD: kw = "ADD   ";
            ALU_ADC: kw = "ADC   ";
            ALU_SBC: kw = "SBC   ";
            ALU_RSC: kw = "RSC   ";
            ALU_TST: kw = "TST   ";
            ALU_TEQ: kw = "TEQ   ";
            ALU_CMP: kw = "CMP   ";
            ALU_CMN: kw = "CMN   ";
            ALU_ORR: kw = "ORR   ";
            ALU_MOV: kw = "MOV   ";
            ALU_BIC: kw = "BIC   ";
            default: kw = "MVN   ";
        endcase
        return kw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Evaluates an ARM condition field against {N,Z,C,V}.
// Revision : 1.0  initial release
// ============================================================================
module cond_eval
    import decode_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       cond_true_o
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = nzcv_i;

    // Condition truth table; the 1111 encoding never executes
    always_comb begin
        cond_true_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_true_o = w_z;
            COND_NE: cond_true_o = ~w_z;
            COND_CS: cond_true_o = w_c;
            COND_CC: cond_true_o = ~w_c;
            COND_MI: cond_true_o = w_n;
            COND_PL: cond_true_o = ~w_n;
            COND_VS: cond_true_o = w_v;
            COND_VC: cond_true_o = ~w_v;
            COND_HI: cond_true_o = w_c & ~w_z;
            COND_LS: cond_true_o = ~w_c | w_z;
            COND_GE: cond_true_o = (w_n == w_v);
            COND_LT: cond_true_o = (w_n != w_v);
            COND_GT: cond_true_o = ~w_z & (w_n == w_v);
            COND_LE: cond_true_o = w_z | (w_n != w_v);
            COND_AL: cond_true_o = 1'b1;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_control.sv
`default_nettype none
// ============================================================================
// Module   : decode_control
// Purpose  : ID-stage control unit: instruction decode, hazard stall mux,
//            flag register and branch / branch-with-link resolution.
// Revision : 1.0  initial release
// ============================================================================
module decode_control
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  psr_flags,
    input  logic        ex_s_en,
    output logic [3:0]  opcode,
    output logic [1:0]  AM,
    output logic        S_enable,
    output logic        load_instr,
    output logic        RF_enable,
    output logic        Size_enable,
    output logic        RW_enable,
    output logic        Enable_signal,
    output logic        BL_instr,
    output logic        B_instr,
    output logic [47:0] keyword,
    output logic        Branch,
    output logic        BranchL
);

    ctrl_t       dec_ctrl;
    ctrl_t       mux_ctrl;
    logic [2:0]  w_cls;
    logic [3:0]  fr_q;
    logic [3:0]  fr_d;
    logic [3:0]  w_flags;
    logic        w_cond_true;
    logic        unused_instr;

    assign w_cls        = instr[27:25];
    assign unused_instr = ^instr[19:0];

    // Decode the instruction class into the raw control bundle
    always_comb begin
        dec_ctrl = '0;
        if (instr != 32'd0) begin
            case (w_cls)
                CLS_DP_REG, CLS_DP_IMM: begin
                    dec_ctrl.am        = (w_cls == CLS_DP_REG) ? AM_SHIFT_IMM : AM_ROT_IMM;
                    dec_ctrl.opcode    = instr[24:21];
                    dec_ctrl.s_enable  = instr[20];
                    // Compare/test opcodes only update flags, never a register
                    dec_ctrl.rf_enable = (instr[24:23] != 2'b10);
                end
                CLS_LS_IMM, CLS_LS_REG: begin
                    dec_ctrl.am            = (w_cls == CLS_LS_IMM) ? AM_LS_IMM : AM_LS_REG;
                    dec_ctrl.opcode        = instr[23] ? ALU_ADD : ALU_SUB;
                    dec_ctrl.load_instr    = instr[20];
                    dec_ctrl.rf_enable     = instr[20];
                    dec_ctrl.rw_enable     = ~instr[20];
                    dec_ctrl.size_enable   = instr[22];
                    dec_ctrl.enable_signal = 1'b1;
                end
                CLS_BR: begin
                    dec_ctrl.bl_instr = instr[24];
                    dec_ctrl.b_instr  = ~instr[24];
                end
                default: dec_ctrl = '0;
            endcase
        end
    end

    // Debug mnemonic, derived from instr alone and never stalled
    always_comb begin
        keyword = "UNDEF ";
        if (instr == 32'd0) begin
            keyword = "NOP   ";
        end else begin
            case (w_cls)
                CLS_DP_REG, CLS_DP_IMM: keyword = dp_mnemonic(instr[24:21]);
                CLS_LS_IMM, CLS_LS_REG: begin
                    case ({instr[20], instr[22]})
                        2'b11:   keyword = "LDRB  ";
                        2'b10:   keyword = "LDR   ";
                        2'b01:   keyword = "STRB  ";
                        default: keyword = "STR   ";
                    endcase
                end
                CLS_BR:  keyword = instr[24] ? "BL    " : "B     ";
                default: keyword = "UNDEF ";
            endcase
        end
    end

    // Hazard mux: a stall injects an all-zero bubble
    always_comb begin
        mux_ctrl = stall ? '0 : dec_ctrl;
    end

    assign opcode        = mux_ctrl.opcode;
    assign AM            = mux_ctrl.am;
    assign S_enable      = mux_ctrl.s_enable;
    assign load_instr    = mux_ctrl.load_instr;
    assign RF_enable     = mux_ctrl.rf_enable;
    assign Size_enable   = mux_ctrl.size_enable;
    assign RW_enable     = mux_ctrl.rw_enable;
    assign Enable_signal = mux_ctrl.enable_signal;
    assign BL_instr      = mux_ctrl.bl_instr;
    assign B_instr       = mux_ctrl.b_instr;

    assign fr_d = alu_flags;

    // Flag register captures the EX-stage ALU flags every cycle
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            fr_q <= 4'd0;
        end else begin
            fr_q <= fr_d;
        end
    end

    // A flag-setting instruction in EX forwards its fresh flags ahead of the PSR
    assign w_flags = ex_s_en ? fr_q : psr_flags;

    cond_eval u_cond_eval (
        .cond_i      (instr[31:28]),
        .nzcv_i      (w_flags),
        .cond_true_o (w_cond_true)
    );

    assign Branch  = w_cond_true & (mux_ctrl.b_instr | mux_ctrl.bl_instr);
    assign BranchL = w_cond_true & mux_ctrl.bl_instr;

endmodule
`default_nettype wire

// File: tb/tb_decode_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_control
// Purpose  : Self-checking bench for decode_control: directed cases followed
//            by randomized instructions against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_control;

    logic        clk = 1'b0;
    logic        R;
    logic [31:0] instr;
    logic        stall;
    logic [3:0]  alu_flags;
    logic [3:0]  psr_flags;
    logic        ex_s_en;
    logic [3:0]  opcode;
    logic [1:0]  AM;
    logic        S_enable, load_instr, RF_enable, Size_enable, RW_enable;
    logic        Enable_signal, BL_instr, B_instr;
    logic [47:0] keyword;
    logic        Branch, BranchL;

    int total = 0;
    int bad   = 0;
    logic [3:0] fr_m;

    string dp_names [16] = '{"AND", "EOR", "SUB", "RSB", "ADD", "ADC", "SBC", "RSC",
                             "TST", "TEQ", "CMP", "CMN", "ORR", "MOV", "BIC", "MVN"};

    decode_control dut (
        .clk           (clk),
        .R             (R),
        .instr         (instr),
        .stall         (stall),
        .alu_flags     (alu_flags),
        .psr_flags     (psr_flags),
        .ex_s_en       (ex_s_en),
        .opcode        (opcode),
        .AM            (AM),
        .S_enable      (S_enable),
        .load_instr    (load_instr),
        .RF_enable     (RF_enable),
        .Size_enable   (Size_enable),
        .RW_enable     (RW_enable),
        .Enable_signal (Enable_signal),
        .BL_instr      (BL_instr),
        .B_instr       (B_instr),
        .keyword       (keyword),
        .Branch        (Branch),
        .BranchL       (BranchL)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pad6(input string s);
        logic [47:0] k = '0;
        for (int i = 0; i < 6; i++) begin
            k = {k[39:0], (i < s.len()) ? s[i] : 8'h20};
        end
        return k;
    endfunction

    // Expected control bundle {opcode,AM,S,load,RF,Size,RW,En,BL,B}
    function automatic logic [13:0] exp_ctl(input logic [31:0] ins, input logic st);
        logic [3:0] op = 0;
        logic [1:0] am = 0;
        logic s = 0, ld = 0, rf = 0, sz = 0, rw = 0, en = 0, bl = 0, b = 0;
        int cls = int'(ins[27:25]);
        if (!st && ins != 0) begin
            if (cls == 0 || cls == 1) begin
                op = ins[24:21];
                am = (cls == 0) ? 2'd1 : 2'd0;
                s  = ins[20];
                rf = !(op >= 8 && op <= 11);
            end else if (cls == 2 || cls == 3) begin
                op = ins[23] ? 4'd4 : 4'd2;
                am = (cls == 2) ? 2'd2 : 2'd3;
                ld = ins[20];
                rf = ins[20];
                rw = !ins[20];
                sz = ins[22];
                en = 1;
            end else if (cls == 5) begin
                bl = ins[24];
                b  = !ins[24];
            end
        end
        return {op, am, s, ld, rf, sz, rw, en, bl, b};
    endfunction

    function automatic logic [47:0] exp_kw(input logic [31:0] ins);
        int cls = int'(ins[27:25]);
        if (ins == 0) return pad6("NOP");
        if (cls <= 1) return pad6(dp_names[ins[24:21]]);
        if (cls == 2 || cls == 3)
            return pad6({ins[20] ? "LDR" : "STR", ins[22] ? "B" : ""});
        if (cls == 5) return pad6(ins[24] ? "BL" : "B");
        return pad6("UNDEF");
    endfunction

    // Conditions come in complementary pairs: even code = predicate, odd = its inverse
    function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
        logic n = f[3], z = f[2], cy = f[1], v = f[0];
        logic p [7];
        p[0] = z;  p[1] = cy;  p[2] = n;  p[3] = v;
        p[4] = cy && !z;
        p[5] = (n == v);
        p[6] = !z && (n == v);
        if (c == 14) return 1'b1;
        if (c == 15) return 1'b0;
        return c[0] ? !p[c >> 1] : p[c >> 1];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [13:0] ctl;
        logic [3:0]  fl;
        logic        ct;
        ctl = exp_ctl(instr, stall);
        fl  = ex_s_en ? fr_m : psr_flags;
        ct  = exp_cond(instr[31:28], fl);
        chk({tag, ".ctl"}, 64'({opcode, AM, S_enable, load_instr, RF_enable, Size_enable,
                                RW_enable, Enable_signal, BL_instr, B_instr}), 64'(ctl));
        chk({tag, ".kw"}, 64'(keyword), 64'(exp_kw(instr)));
        chk({tag, ".br"}, 64'({Branch, BranchL}),
            64'({ct && (ctl[1] || ctl[0]), ct && ctl[1]}));
    endtask

    task automatic set_in(input logic [31:0] i, input logic s, input logic [3:0] psr,
                          input logic es);
        instr = i; stall = s; psr_flags = psr; ex_s_en = es;
        #1;
    endtask

    initial begin
        R = 1'b0; instr = 32'd0; stall = 1'b0; alu_flags = 4'b0100;
        psr_flags = 4'd0; ex_s_en = 1'b1; fr_m = 4'd0;

        // Reset holds fr at zero despite alu_flags
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        set_in(32'h0A000004, 1'b0, 4'b0000, 1'b1);
        chk("rst_beq_branch", 64'(Branch), 64'd0);
        check_all("rst_nop");
        @(negedge clk);
        R = 1'b1;
        @(posedge clk); fr_m = alu_flags;
        #1;
        chk("rel_beq_branch", 64'(Branch), 64'd1);

        // ADD
        @(negedge clk);
        set_in(32'hE0821003, 1'b0, 4'b0000, 1'b0);
        chk("add_op", 64'({opcode, AM}), 64'({4'b0100, 2'b01}));
        chk("add_bits", 64'({RF_enable, S_enable, Enable_signal, Branch}), 64'(4'b1000));
        chk("add_kw", 64'(keyword), 64'(48'h414444202020));
        check_all("add");

        // CMP
        set_in(32'hE3530000, 1'b0, 4'b0000, 1'b0);
        chk("cmp_op", 64'({opcode, AM, S_enable, RF_enable}), 64'({4'b1010, 2'b00, 1'b1, 1'b0}));
        check_all("cmp");

        // LDRB
        set_in(32'hE5D21004, 1'b0, 4'b0000, 1'b0);
        chk("ldrb_ctl", 64'({opcode, AM, load_instr, RF_enable, Size_enable, RW_enable,
                             Enable_signal}), 64'({4'b0100, 2'b10, 5'b11101}));
        check_all("ldrb");

        // BEQ with PSR flags
        set_in(32'h0A000004, 1'b0, 4'b0000, 1'b0);
        chk("beq_z0", 64'({Branch, BranchL}), 64'd0);
        set_in(32'h0A000004, 1'b0, 4'b0100, 1'b0);
        chk("beq_z1", 64'({Branch, BranchL}), 64'(2'b10));
        set_in(32'hEB000004, 1'b0, 4'b0100, 1'b0);
        chk("bl", 64'({BL_instr, Branch, BranchL}), 64'(3'b111));
        check_all("bl");

        // Stall bubble on BL
        set_in(32'hEB000004, 1'b1, 4'b0100, 1'b0);
        chk("stall_ctl", 64'({opcode, AM, S_enable, load_instr, RF_enable, Size_enable,
                              RW_enable, Enable_signal, BL_instr, B_instr, Branch, BranchL}), 64'd0);
        chk("stall_kw", 64'(keyword), 64'(48'h424C20202020));
        check_all("stall");

        // Flag path latency: new alu_flags reach Branch one edge later
        set_in(32'h1A000000, 1'b0, 4'b0000, 1'b1);
        alu_flags = 4'b0100;
        @(posedge clk); fr_m = alu_flags;
        @(negedge clk);
        alu_flags = 4'b0000;
        #1;
        chk("bne_before", 64'(Branch), 64'd0);
        @(posedge clk); fr_m = alu_flags;
        #1;
        chk("bne_after", 64'(Branch), 64'd1);

        // Asynchronous reset between edges clears fr immediately
        set_in(32'h0A000000, 1'b0, 4'b1111, 1'b1);
        alu_flags = 4'b0100;
        @(posedge clk); fr_m = alu_flags;
        #2;
        chk("async_pre", 64'(Branch), 64'd1);
        R = 1'b0; fr_m = 4'd0;
        #1;
        chk("async_clr", 64'(Branch), 64'd0);
        check_all("async");
        @(negedge clk);
        R = 1'b1;

        // Randomized instructions against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            @(negedge clk);
            ins = $urandom;
            ins[27:25] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) ins = 32'd0;
            alu_flags = 4'($urandom);
            set_in(ins, ($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom));
            check_all("rnd");
            @(posedge clk);
            if (R) fr_m = alu_flags;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
